// File: rtl/rover_pkg.sv
// rover_pkg: direction codes and FSM state encoding shared by the rover motion blocks
package rover_pkg;

    localparam logic [3:0] FWD   = 4'b0101;
    localparam logic [3:0] REV   = 4'b1010;
    localparam logic [3:0] PIV_L = 4'b0110;
    localparam logic [3:0] PIV_R = 4'b1001;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FOLLOW  = 3'd1,
        AV_REV  = 3'd2,
        AV_TURN = 3'd3,
        AV_FWD  = 3'd4,
        HALT    = 3'd5
    } state_t;

    function automatic logic drives(input state_t s);
        return s == FOLLOW || s == AV_REV || s == AV_TURN || s == AV_FWD;
    endfunction

endpackage

// File: rtl/drive_sequencer_sync_debounce.sv
// sync_debounce: two-flop synchroniser followed by an optional stability filter
module sync_debounce #(
    parameter int DEBOUNCE_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level
);

    logic s1_q, s2_q;

    // bring the asynchronous pin into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    generate
        if (DEBOUNCE_CYC == 0) begin : g_raw
            assign level = s2_q;
        end else begin : g_deb
            localparam int CW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);
            logic [CW-1:0] cnt_q, cnt_d;
            logic          lvl_q, lvl_d;
            // count consecutive cycles the synchronised input disagrees with the filtered level
            always_comb begin
                cnt_d = (s2_q == lvl_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                lvl_d = (s2_q != lvl_q && cnt_q == LAST) ? s2_q : lvl_q;
            end
            // filter state
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end
            assign level = lvl_q;
        end
    endgenerate

endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer: prioritised line-follow / obstacle-avoid / red-halt motor FSM with PWM enables
module drive_sequencer
    import rover_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1024,
    parameter int REV_CYC      = 50000,
    parameter int TURN_CYC     = 100000,
    parameter int FWD_CYC      = 150000,
    parameter int PWM_BITS     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [3:0]          lf_cmd,
    input  logic                lf_valid,
    input  logic                proxim,
    input  logic                red,
    input  logic [PWM_BITS-1:0] duty,
    output logic [3:0]          motor_in,
    output logic [1:0]          motor_en,
    output logic [2:0]          state,
    output logic [7:0]          avoid_cnt
);

    localparam int MAXC = (REV_CYC > TURN_CYC) ? ((REV_CYC > FWD_CYC) ? REV_CYC : FWD_CYC)
                                               : ((TURN_CYC > FWD_CYC) ? TURN_CYC : FWD_CYC);
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] REV_LD  = CW'(REV_CYC - 1);
    localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYC - 1);
    localparam logic [CW-1:0] FWD_LD  = CW'(FWD_CYC - 1);

    logic                prox_f, red_s, prox_prev_q;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PWM_BITS-1:0] pc_q, pc_d;
    logic [3:0]          lf_q, lf_d;
    logic [3:0]          motor_in_q, motor_in_d;
    logic [1:0]          motor_en_q, motor_en_d;
    logic [7:0]          avoid_q, avoid_d;

    sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_prox (
        .clk   (clk),
        .rst   (rst),
        .din   (proxim),
        .level (prox_f)
    );

    sync_debounce #(.DEBOUNCE_CYC(0)) u_red (
        .clk   (clk),
        .rst   (rst),
        .din   (red),
        .level (red_s)
    );

    // next state: red overrides obstacle, obstacle overrides normal phase progress
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = FOLLOW;
            FOLLOW:  if (prox_f && !prox_prev_q) state_d = AV_REV;
            AV_REV:  if (cnt_q == '0) state_d = AV_TURN;
            AV_TURN: if (cnt_q == '0) state_d = AV_FWD;
            AV_FWD:  state_d = prox_f ? AV_REV : (cnt_q == '0 ? FOLLOW : AV_FWD);
            HALT:    if (!red_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && state_q != HALT && red_s) state_d = HALT;
    end

    // phase timer reloads on every state change so each phase lasts exactly its cycle count
    always_comb begin
        cnt_d = state_d != state_q ? (state_d == AV_REV  ? REV_LD  :
                                      state_d == AV_TURN ? TURN_LD :
                                      state_d == AV_FWD  ? FWD_LD  : '0)
                                   : (cnt_q != '0 ? cnt_q - 1'b1 : '0);
    end

    // datapath: PWM counter, accepted steering command, registered bridge outputs, manoeuvre count
    always_comb begin
        pc_d       = pc_q + 1'b1;
        lf_d       = (state_q == FOLLOW && lf_valid) ? lf_cmd : lf_q;
        motor_in_d = state_d == IDLE    ? FWD   :
                     state_d == FOLLOW  ? lf_d  :
                     state_d == AV_REV  ? REV   :
                     state_d == AV_TURN ? PIV_L :
                     state_d == AV_FWD  ? FWD   : motor_in_q;
        motor_en_d = {2{drives(state_d) && (pc_q < duty)}};
        avoid_d    = (state_q == AV_FWD && state_d == FOLLOW && avoid_q != 8'hFF) ? avoid_q + 8'd1 : avoid_q;
    end

    // all state and outputs registered together
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pc_q        <= '0;
            lf_q        <= FWD;
            motor_in_q  <= FWD;
            motor_en_q  <= 2'b00;
            avoid_q     <= 8'd0;
            prox_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            lf_q        <= lf_d;
            motor_in_q  <= motor_in_d;
            motor_en_q  <= motor_en_d;
            avoid_q     <= avoid_d;
            prox_prev_q <= prox_f;
        end
    end

    assign motor_in  = motor_in_q;
    assign motor_en  = motor_en_q;
    assign state     = state_q;
    assign avoid_cnt = avoid_q;

endmodule
